// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM states, opcode classes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_ctrl_pkg;

    // Major opcode field values recognised by the controller
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_HALT   = 7'b0000000;

    // ALU operation select driven during EXEC
    localparam logic [1:0] ALUOP_R   = 2'b00;
    localparam logic [1:0] ALUOP_I   = 2'b01;
    localparam logic [1:0] ALUOP_ADD = 2'b10;  // load/store address generation
    localparam logic [1:0] ALUOP_SUB = 2'b11;  // branch compare

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    // CLS_R is encoded as zero so the reset value of the class register is R
    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_HALT    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_e;

    // Classes that need a data-memory access phase
    function automatic logic is_mem_class(input op_class_e c);
        return (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier: maps the 7-bit opcode to an opcode class.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the input.
//
// Ports:
//   op        in   7  opcode field
//   op_class  out  3  op_class_e encoding of the opcode class
import rv_ctrl_pkg::*;

module op_class_decode (
    input  logic [6:0] op,
    output logic [2:0] op_class
);

    op_class_e cls;

    always_comb begin
        cls = CLS_ILLEGAL;
        case (op)
            OP_R:      cls = CLS_R;
            OP_I:      cls = CLS_I;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            OP_HALT:   cls = CLS_HALT;
            default:   cls = CLS_ILLEGAL;
        endcase
    end

    assign op_class = cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB) with retire counter.
// Latency: FETCH->FETCH 3 cycles (branch), 4 (R/I/store), 5 (load) plus one per memory wait cycle.
// Backpressure: mem_ready_i low stalls FETCH/MEM with every output held; no timeout.
//
// Ports:
//   clk_i, rst_i (async active-low)      clock and reset
//   start_i                              leave IDLE (only sampled in IDLE)
//   Op_i[6:0], Zero_i                    instruction opcode, ALU zero flag
//   mem_ready_i                          memory completes current access
//   PCWrite_o, PCSrc_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o,
//   ALUOp_o[1:0], ALUSrc_o, RegWrite_o, MemtoReg_o   datapath controls
//   busy_o, done_o, illegal_o            status; done/illegal are one-cycle pulses
//   retired_o[31:0]                      retired instruction count (wraps)
import rv_ctrl_pkg::*;

module multicycle_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [6:0]  Op_i,
    input  logic        Zero_i,
    input  logic        mem_ready_i,
    output logic        PCWrite_o,
    output logic        PCSrc_o,
    output logic        IRWrite_o,
    output logic        IorD_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic [1:0]  ALUOp_o,
    output logic        ALUSrc_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        illegal_o,
    output logic [31:0] retired_o
);

    state_e      state_q, state_d;
    op_class_e   class_q, class_d;
    op_class_e   dec_class;
    logic [2:0]  dec_raw;
    logic [31:0] retired_q;
    logic        retire;

    op_class_decode u_decode (
        .op       (Op_i),
        .op_class (dec_raw)
    );

    assign dec_class = op_class_e'(dec_raw);

    // State, class and retire counter. Reset drives the state to IDLE
    // asynchronously, so all state-decoded strobes (including an in-flight
    // MemRead/MemWrite) drop without waiting for a clock edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            class_q   <= CLS_R;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        retire     = 1'b0;
        PCWrite_o  = 1'b0;
        PCSrc_o    = 1'b0;
        IRWrite_o  = 1'b0;
        IorD_o     = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        ALUOp_o    = ALUOP_R;
        ALUSrc_o   = 1'b0;
        RegWrite_o = 1'b0;
        MemtoReg_o = 1'b0;
        done_o     = 1'b0;
        illegal_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // Instruction address on the bus; IR and PC+4 load together
                // in the cycle memory completes.
                MemRead_o = 1'b1;
                if (mem_ready_i) begin
                    IRWrite_o = 1'b1;
                    PCWrite_o = 1'b1;
                    state_d   = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Class is taken from the live opcode here and held for the
                // remaining phases of the instruction.
                class_d = dec_class;
                case (dec_class)
                    CLS_HALT: begin
                        done_o  = 1'b1;
                        state_d = ST_IDLE;
                    end
                    CLS_ILLEGAL: begin
                        illegal_o = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_EXEC;
                    end
                endcase
            end

            ST_EXEC: begin
                case (class_q)
                    CLS_R: begin
                        ALUOp_o  = ALUOP_R;
                        ALUSrc_o = 1'b0;
                        state_d  = ST_WB;
                    end
                    CLS_I: begin
                        ALUOp_o  = ALUOP_I;
                        ALUSrc_o = 1'b1;
                        state_d  = ST_WB;
                    end
                    CLS_BRANCH: begin
                        // Taken branch loads the target; either way the
                        // branch is complete and retires here.
                        ALUOp_o   = ALUOP_SUB;
                        ALUSrc_o  = 1'b0;
                        PCWrite_o = Zero_i;
                        PCSrc_o   = Zero_i;
                        retire    = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    default: begin
                        if (is_mem_class(class_q)) begin
                            ALUOp_o  = ALUOP_ADD;
                            ALUSrc_o = 1'b1;
                            state_d  = ST_MEM;
                        end else begin
                            state_d  = ST_FETCH;
                        end
                    end
                endcase
            end

            ST_MEM: begin
                IorD_o = 1'b1;
                case (class_q)
                    CLS_LOAD: begin
                        MemRead_o = 1'b1;
                        if (mem_ready_i) begin
                            state_d = ST_WB;
                        end
                    end
                    CLS_STORE: begin
                        MemWrite_o = 1'b1;
                        if (mem_ready_i) begin
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                    default: begin
                        state_d = ST_FETCH;
                    end
                endcase
            end

            ST_WB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = (class_q == CLS_LOAD);
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign retired_o = retired_q;

endmodule
